uctl_dmatx: RTL and testbench

//  System-to-local DMA engine; opposite direction of the Rx DMA. On start from the Tx system endpoint controller
//  (sept) it requests an AHB-master read of len bytes from system memory, pops returned words from the AHB-master

---
 rtl/uctl_dmatx_if.sv | 48 ++++
 rtl/uctl_dmatx.sv | 113 +++++++++++
 tb/tb_uctl_dmatx.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uctl_dmatx_if.sv
// Signal bundle between the Tx DMA engine and its neighbours: sept control,
// AHB-master read path and local memory interface.
interface uctl_dmatx_if #(
  parameter int CNTR_WD         = 20,
  parameter int DMA_WR_FIFO_ADR = 4,
  parameter int DATA_SIZE       = 32,
  parameter int ADDR_SIZE       = 32
);
  logic [ADDR_SIZE-1:0]     sept2dmaTx_sRdAddr;
  logic [ADDR_SIZE-1:0]     sept2dmaTx_laddrIn;
  logic                     sept2dmaTx_dmaStart;
  logic [CNTR_WD-1:0]       sept2dmaTx_len;
  logic [ADDR_SIZE-1:0]     sept2dmaTx_epStartAddr;
  logic [ADDR_SIZE-1:0]     sept2dmaTx_epEndAddr;
  logic                     sept2dmaTx_sRdWr;
  logic                     dmaTx2sept_dn;
  logic [ADDR_SIZE-1:0]     dmaTx2ahbm_sRdAddr;
  logic                     dmaTx2ahbm_sRdWr;
  logic [CNTR_WD-1:0]       dmaTx2ahbm_len;
  logic                     dmaTx2ahbm_stransEn;
  logic                     ahbm2dmaTx_dn;
  logic [DMA_WR_FIFO_ADR:0] ahbm2dmaTx_fillCnt;
  logic [DATA_SIZE-1:0]     ahbm2dmaTx_data;
  logic                     dmaTx2ahbm_rd;
  logic [ADDR_SIZE-1:0]     dmaTx2mif_addr;
  logic [DATA_SIZE-1:0]     dmaTx2mif_data;
  logic [3:0]               dmaTx2mif_BE;
  logic                     dmaTx2mif_wrReq;
  logic                     mif2dmaTx_ack;

  modport master (
    input  sept2dmaTx_sRdAddr, sept2dmaTx_laddrIn, sept2dmaTx_dmaStart, sept2dmaTx_len,
           sept2dmaTx_epStartAddr, sept2dmaTx_epEndAddr, sept2dmaTx_sRdWr,
           ahbm2dmaTx_dn, ahbm2dmaTx_fillCnt, ahbm2dmaTx_data, mif2dmaTx_ack,
    output dmaTx2sept_dn, dmaTx2ahbm_sRdAddr, dmaTx2ahbm_sRdWr, dmaTx2ahbm_len,
           dmaTx2ahbm_stransEn, dmaTx2ahbm_rd, dmaTx2mif_addr, dmaTx2mif_data,
           dmaTx2mif_BE, dmaTx2mif_wrReq
  );

  modport slave (
    output sept2dmaTx_sRdAddr, sept2dmaTx_laddrIn, sept2dmaTx_dmaStart, sept2dmaTx_len,
           sept2dmaTx_epStartAddr, sept2dmaTx_epEndAddr, sept2dmaTx_sRdWr,
           ahbm2dmaTx_dn, ahbm2dmaTx_fillCnt, ahbm2dmaTx_data, mif2dmaTx_ack,
    input  dmaTx2sept_dn, dmaTx2ahbm_sRdAddr, dmaTx2ahbm_sRdWr, dmaTx2ahbm_len,
           dmaTx2ahbm_stransEn, dmaTx2ahbm_rd, dmaTx2mif_addr, dmaTx2mif_data,
           dmaTx2mif_BE, dmaTx2mif_wrReq
  );
endinterface

// File: rtl/uctl_dmatx.sv
// System-to-local DMA: pops AHB read FIFO words through a one-word hold register
// into the endpoint local buffer, wrapping inside the endpoint window.
module uctl_dmatx #(
  parameter int CNTR_WD   = 20,
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 32
) (
  input  logic          core_clk,
  input  logic          uctl_rst_n,
  input  logic          sw_rst,
  uctl_dmatx_if.master  bus
);
  typedef enum logic {IDLE, TRANS} state_t;

  state_t               state_reg;
  logic [ADDR_SIZE-1:0] addr_reg;
  logic [CNTR_WD-1:0]   wr_bytes_reg;
  logic [CNTR_WD-1:0]   pop_words_reg;
  logic                 ahb_done_reg;
  logic [DATA_SIZE-1:0] hold_data_reg;
  logic                 hold_vld_reg;
  logic                 strans_reg;

  logic                 write_done;
  logic                 pop;
  logic                 start_zero;
  logic                 finish;
  logic [CNTR_WD:0]     len_round;
  logic [ADDR_SIZE-1:0] addr_next;

  assign bus.dmaTx2ahbm_sRdAddr = bus.sept2dmaTx_sRdAddr;
  assign bus.dmaTx2ahbm_sRdWr   = bus.sept2dmaTx_sRdWr;
  assign bus.dmaTx2ahbm_len     = bus.sept2dmaTx_len;

  assign write_done = hold_vld_reg & bus.mif2dmaTx_ack;
  // A new word may enter the hold register only when it is empty or draining this cycle.
  assign pop = !sw_rst && (state_reg == TRANS) && (bus.ahbm2dmaTx_fillCnt != '0) &&
               (pop_words_reg != '0) && (!hold_vld_reg || write_done);
  assign start_zero = (state_reg == IDLE) && bus.sept2dmaTx_dmaStart &&
                      (bus.sept2dmaTx_len == '0);
  assign finish = (state_reg == TRANS) && (wr_bytes_reg == '0) && !hold_vld_reg &&
                  (ahb_done_reg || bus.ahbm2dmaTx_dn);
  assign len_round = {1'b0, bus.sept2dmaTx_len} + (CNTR_WD+1)'(3);
  assign addr_next = (addr_reg >= bus.sept2dmaTx_epEndAddr) ? bus.sept2dmaTx_epStartAddr
                                                            : addr_reg + ADDR_SIZE'(4);

  assign bus.dmaTx2ahbm_rd       = pop;
  assign bus.dmaTx2sept_dn       = !sw_rst && (start_zero || finish);
  assign bus.dmaTx2ahbm_stransEn = strans_reg;
  assign bus.dmaTx2mif_wrReq     = hold_vld_reg;
  assign bus.dmaTx2mif_addr      = addr_reg;
  assign bus.dmaTx2mif_data      = hold_data_reg;

  always_comb begin
    bus.dmaTx2mif_BE = 4'b0000;
    if (wr_bytes_reg >= CNTR_WD'(4))      bus.dmaTx2mif_BE = 4'b1111;
    else if (wr_bytes_reg == CNTR_WD'(3)) bus.dmaTx2mif_BE = 4'b0111;
    else if (wr_bytes_reg == CNTR_WD'(2)) bus.dmaTx2mif_BE = 4'b0011;
    else if (wr_bytes_reg == CNTR_WD'(1)) bus.dmaTx2mif_BE = 4'b0001;
  end

  always_ff @(posedge core_clk or negedge uctl_rst_n) begin
    if (!uctl_rst_n) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      wr_bytes_reg  <= '0;
      pop_words_reg <= '0;
      ahb_done_reg  <= 1'b0;
      hold_data_reg <= '0;
      hold_vld_reg  <= 1'b0;
      strans_reg    <= 1'b0;
    end else if (sw_rst) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      wr_bytes_reg  <= '0;
      pop_words_reg <= '0;
      ahb_done_reg  <= 1'b0;
      hold_data_reg <= '0;
      hold_vld_reg  <= 1'b0;
      strans_reg    <= 1'b0;
    end else begin
      strans_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.sept2dmaTx_dmaStart && bus.sept2dmaTx_len != '0) begin
            state_reg     <= TRANS;
            strans_reg    <= 1'b1;
            addr_reg      <= bus.sept2dmaTx_laddrIn;
            wr_bytes_reg  <= bus.sept2dmaTx_len;
            pop_words_reg <= {1'b0, len_round[CNTR_WD:2]};
            ahb_done_reg  <= 1'b0;
          end
        end
        TRANS: begin
          if (bus.ahbm2dmaTx_dn) ahb_done_reg <= 1'b1;
          if (pop) begin
            hold_data_reg <= bus.ahbm2dmaTx_data;
            hold_vld_reg  <= 1'b1;
            pop_words_reg <= pop_words_reg - CNTR_WD'(1);
          end else if (write_done) begin
            hold_vld_reg <= 1'b0;
          end
          if (write_done) begin
            wr_bytes_reg <= (wr_bytes_reg >= CNTR_WD'(4)) ? wr_bytes_reg - CNTR_WD'(4) : '0;
            addr_reg     <= addr_next;
          end
          if (finish) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uctl_dmatx.sv
// Directed bench for uctl_dmatx: FIFO model, mif write logger, scenario tasks.
module tb_uctl_dmatx;
  logic core_clk = 1'b0;
  logic uctl_rst_n = 1'b0;
  logic sw_rst = 1'b0;
  always #5 core_clk = ~core_clk;

  uctl_dmatx_if #(.CNTR_WD(20), .DMA_WR_FIFO_ADR(4), .DATA_SIZE(32), .ADDR_SIZE(32)) bus ();
  uctl_dmatx #(.CNTR_WD(20), .DATA_SIZE(32), .ADDR_SIZE(32)) dut (
    .core_clk(core_clk), .uctl_rst_n(uctl_rst_n), .sw_rst(sw_rst), .bus(bus));

  int errors = 0;
  int checks = 0;

  // Show-ahead read FIFO model: words pushed by the bench, popped when rd was seen.
  logic [31:0] fifo_mem [0:31];
  int fifo_wr = 0;
  int pop_cnt = 0;
  bit pop_pend = 1'b0;
  assign bus.ahbm2dmaTx_fillCnt = 5'(fifo_wr - pop_cnt);
  assign bus.ahbm2dmaTx_data    = fifo_mem[pop_cnt[4:0]];

  int cyc = 0;
  always @(posedge core_clk) begin
    cyc <= cyc + 1;
    if (pop_pend) pop_cnt <= pop_cnt + 1;
  end

  logic [31:0] log_addr [0:63];
  logic [31:0] log_data [0:63];
  logic [3:0]  log_be   [0:63];
  int          log_cyc  [0:63];
  int wr_n = 0, pop_n = 0, strans_n = 0, dn_n = 0, dn_busy = 0;

  always @(negedge core_clk) begin
    #2;
    pop_pend = bus.dmaTx2ahbm_rd;
    if (bus.dmaTx2mif_wrReq && bus.mif2dmaTx_ack) begin
      if (wr_n < 64) begin
        log_addr[wr_n] = bus.dmaTx2mif_addr;
        log_data[wr_n] = bus.dmaTx2mif_data;
        log_be[wr_n]   = bus.dmaTx2mif_BE;
        log_cyc[wr_n]  = cyc;
      end
      wr_n++;
    end
    if (bus.dmaTx2ahbm_rd) pop_n++;
    if (bus.dmaTx2ahbm_stransEn) strans_n++;
    if (bus.dmaTx2sept_dn) dn_n++;
    if (bus.dmaTx2sept_dn && bus.dmaTx2mif_wrReq) dn_busy++;
  end

  task automatic push(input logic [31:0] w);
    fifo_mem[fifo_wr[4:0]] = w;
    fifo_wr++;
  endtask

  task automatic flush();
    fifo_wr = pop_cnt;
  endtask

  task automatic run_xfer(input logic [19:0] len, input logic [31:0] laddr, input int ahb_dn_cyc,
                          input int stall_in, output bit got_dn, output int dn_at, output bit stall_bad);
    int stall;
    bit s_cap, stalled;
    logic [31:0] s_addr, s_data;
    logic [3:0] s_be;
    stall = stall_in; got_dn = 0; dn_at = -1; stall_bad = 0; s_cap = 0;
    s_addr = '0; s_data = '0; s_be = '0;
    bus.sept2dmaTx_len = len;
    bus.sept2dmaTx_laddrIn = laddr;
    bus.sept2dmaTx_dmaStart = 1'b1;
    for (int c = 0; c < 80 && !got_dn; c++) begin
      @(negedge core_clk);
      bus.ahbm2dmaTx_dn = (c == ahb_dn_cyc);
      stalled = 0;
      if (stall > 0 && bus.dmaTx2mif_wrReq) begin
        stalled = 1;
        bus.mif2dmaTx_ack = 1'b0;
        stall--;
        if (!s_cap) begin
          s_cap = 1; s_addr = bus.dmaTx2mif_addr; s_data = bus.dmaTx2mif_data; s_be = bus.dmaTx2mif_BE;
        end else if (bus.dmaTx2mif_addr !== s_addr || bus.dmaTx2mif_data !== s_data ||
                     bus.dmaTx2mif_BE !== s_be) begin
          stall_bad = 1;
        end
      end else begin
        if (s_cap && stall > 0) stall_bad = 1;
        bus.mif2dmaTx_ack = 1'b1;
      end
      #1;
      if (stalled && bus.dmaTx2ahbm_rd) stall_bad = 1;
      if (bus.dmaTx2sept_dn) begin got_dn = 1; dn_at = c; end
    end
    @(posedge core_clk); #1;
    bus.sept2dmaTx_dmaStart = 1'b0;
    bus.ahbm2dmaTx_dn = 1'b0;
    bus.mif2dmaTx_ack = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    checks += 8;
    if (bus.dmaTx2ahbm_stransEn !== 1'b0) begin errors++; $display("FAIL rst_strans: got %b want 0", bus.dmaTx2ahbm_stransEn); end
    if (bus.dmaTx2sept_dn !== 1'b0) begin errors++; $display("FAIL rst_dn: got %b want 0", bus.dmaTx2sept_dn); end
    if (bus.dmaTx2ahbm_rd !== 1'b0) begin errors++; $display("FAIL rst_rd: got %b want 0", bus.dmaTx2ahbm_rd); end
    if (bus.dmaTx2mif_wrReq !== 1'b0) begin errors++; $display("FAIL rst_wrreq: got %b want 0", bus.dmaTx2mif_wrReq); end
    if (bus.dmaTx2mif_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", bus.dmaTx2mif_addr); end
    if (bus.dmaTx2mif_BE !== 4'h0) begin errors++; $display("FAIL rst_be: got %h want 0", bus.dmaTx2mif_BE); end
    if (bus.dmaTx2ahbm_sRdAddr !== 32'h8000_0000) begin errors++; $display("FAIL pass_saddr: got %h want 80000000", bus.dmaTx2ahbm_sRdAddr); end
    if (bus.dmaTx2ahbm_sRdWr !== 1'b1 || bus.dmaTx2ahbm_len !== 20'h0) begin errors++;
      $display("FAIL pass_rdwr_len: got %b/%h want 1/0", bus.dmaTx2ahbm_sRdWr, bus.dmaTx2ahbm_len); end
    $display("reset: outputs checked");
    @(posedge core_clk); #1 uctl_rst_n = 1'b1;
    @(posedge core_clk); #1;
  endtask

  task automatic test_len16();
    int wb, pb, sb, db, dn_at; bit got, sbad;
    wb = wr_n; pb = pop_n; sb = strans_n; db = dn_n;
    for (int i = 0; i < 4; i++) push(32'hA000_0000 + 32'(i));
    run_xfer(20'd16, 32'h100, 3, 0, got, dn_at, sbad);
    checks += 6;
    if (!got || dn_at < 3) begin errors++; $display("FAIL len16_dn: got dn=%0d at %0d want 1 at>=3", got, dn_at); end
    if (wr_n - wb != 4) begin errors++; $display("FAIL len16_nwr: got %0d want 4", wr_n - wb); end
    if (pop_n - pb != 4) begin errors++; $display("FAIL len16_pops: got %0d want 4", pop_n - pb); end
    if (strans_n - sb != 1) begin errors++; $display("FAIL len16_strans: got %0d want 1", strans_n - sb); end
    if (dn_n - db != 1) begin errors++; $display("FAIL len16_dncount: got %0d want 1", dn_n - db); end
    if (log_cyc[wb+3] - log_cyc[wb] != 3) begin errors++; $display("FAIL len16_rate: got %0d cycles want 3", log_cyc[wb+3] - log_cyc[wb]); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (log_addr[wb+i] !== 32'h100 + 32'(4*i) || log_data[wb+i] !== 32'hA000_0000 + 32'(i) || log_be[wb+i] !== 4'hF) begin
        errors++;
        $display("FAIL len16_wr%0d: got %h/%h/%h want %h/%h/f", i, log_addr[wb+i], log_data[wb+i], log_be[wb+i],
                 32'h100 + 32'(4*i), 32'hA000_0000 + 32'(i));
      end
    end
    $display("len16: %0d writes, dn at cycle %0d", wr_n - wb, dn_at);
  endtask

  task automatic test_len7();
    int wb, pb, dn_at; bit got, sbad;
    wb = wr_n; pb = pop_n;
    push(32'h1111_1111); push(32'h2222_2222); push(32'h3333_3333);
    run_xfer(20'd7, 32'h110, 15, 0, got, dn_at, sbad);
    checks += 5;
    if (!got || dn_at != 15) begin errors++; $display("FAIL len7_dn: got dn=%0d at %0d want 1 at 15", got, dn_at); end
    if (pop_n - pb != 2) begin errors++; $display("FAIL len7_pops: got %0d want 2", pop_n - pb); end
    if (wr_n - wb != 2) begin errors++; $display("FAIL len7_nwr: got %0d want 2", wr_n - wb); end
    if (log_be[wb] !== 4'hF || log_be[wb+1] !== 4'h7) begin errors++; $display("FAIL len7_be: got %h,%h want f,7", log_be[wb], log_be[wb+1]); end
    if (log_addr[wb+1] !== 32'h114 || log_data[wb+1] !== 32'h2222_2222) begin errors++;
      $display("FAIL len7_wr1: got %h/%h want 114/22222222", log_addr[wb+1], log_data[wb+1]); end
    $display("len7: pops %0d, BE %h then %h", pop_n - pb, log_be[wb], log_be[wb+1]);
    flush();
  endtask

  task automatic test_wrap();
    int wb, dn_at; bit got, sbad;
    logic [31:0] exp_a [0:3];
    exp_a[0] = 32'h138; exp_a[1] = 32'h13C; exp_a[2] = 32'h100; exp_a[3] = 32'h104;
    wb = wr_n;
    for (int i = 0; i < 4; i++) push(32'hB000_0000 + 32'(i));
    run_xfer(20'd16, 32'h138, 2, 0, got, dn_at, sbad);
    checks++;
    if (!got) begin errors++; $display("FAIL wrap_dn: got 0 want 1"); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (log_addr[wb+i] !== exp_a[i]) begin errors++; $display("FAIL wrap_addr%0d: got %h want %h", i, log_addr[wb+i], exp_a[i]); end
    end
    $display("wrap: addrs %h %h %h %h", log_addr[wb], log_addr[wb+1], log_addr[wb+2], log_addr[wb+3]);
  endtask

  task automatic test_ack_stall();
    int wb, pb, dn_at; bit got, sbad;
    wb = wr_n; pb = pop_n;
    push(32'hC0DE_0001); push(32'hC0DE_0002);
    run_xfer(20'd8, 32'h120, 2, 5, got, dn_at, sbad);
    checks += 5;
    if (sbad) begin errors++; $display("FAIL stall_stable: got unstable/pop during stall want stable"); end
    if (!got) begin errors++; $display("FAIL stall_dn: got 0 want 1"); end
    if (wr_n - wb != 2 || pop_n - pb != 2) begin errors++; $display("FAIL stall_counts: got wr=%0d pop=%0d want 2/2", wr_n - wb, pop_n - pb); end
    if (log_addr[wb] !== 32'h120 || log_data[wb] !== 32'hC0DE_0001) begin errors++;
      $display("FAIL stall_wr0: got %h/%h want 120/c0de0001", log_addr[wb], log_data[wb]); end
    if (log_addr[wb+1] !== 32'h124 || log_data[wb+1] !== 32'hC0DE_0002) begin errors++;
      $display("FAIL stall_wr1: got %h/%h want 124/c0de0002", log_addr[wb+1], log_data[wb+1]); end
    $display("ack_stall: dn at cycle %0d", dn_at);
  endtask

  task automatic test_len0();
    int wb, pb, sb, dn_at; bit got, sbad;
    wb = wr_n; pb = pop_n; sb = strans_n;
    push(32'hDEAD_BEEF);
    run_xfer(20'd0, 32'h100, -1, 0, got, dn_at, sbad);
    repeat (3) @(posedge core_clk);
    #1;
    checks += 2;
    if (!got || dn_at != 0) begin errors++; $display("FAIL len0_dn: got dn=%0d at %0d want 1 at 0", got, dn_at); end
    if (wr_n != wb || pop_n != pb || strans_n != sb) begin errors++;
      $display("FAIL len0_quiet: got wr=%0d pop=%0d strans=%0d want 0/0/0", wr_n - wb, pop_n - pb, strans_n - sb); end
    $display("len0: dn at cycle %0d", dn_at);
    flush();
  endtask

  task automatic test_sw_rst();
    int wb, db, dn_at; bit got, sbad, reached;
    wb = wr_n; db = dn_n; reached = 0;
    for (int i = 0; i < 8; i++) push(32'hE000_0000 + 32'(i));
    bus.sept2dmaTx_len = 20'd32; bus.sept2dmaTx_laddrIn = 32'h100; bus.sept2dmaTx_dmaStart = 1'b1;
    for (int c = 0; c < 40 && !reached; c++) begin
      @(negedge core_clk); #3;
      if (wr_n - wb >= 2) reached = 1;
    end
    checks++;
    if (!reached) begin errors++; $display("FAIL swrst_progress: got %0d writes want 2", wr_n - wb); end
    sw_rst = 1'b1;
    @(posedge core_clk); #1;
    sw_rst = 1'b0; bus.sept2dmaTx_dmaStart = 1'b0;
    @(negedge core_clk); #1;
    checks += 3;
    if (bus.dmaTx2mif_wrReq !== 1'b0 || bus.dmaTx2ahbm_rd !== 1'b0) begin errors++;
      $display("FAIL swrst_idle: got wrReq=%b rd=%b want 0/0", bus.dmaTx2mif_wrReq, bus.dmaTx2ahbm_rd); end
    if (bus.dmaTx2mif_BE !== 4'h0 || bus.dmaTx2mif_addr !== 32'h0) begin errors++;
      $display("FAIL swrst_clear: got BE=%h addr=%h want 0/0", bus.dmaTx2mif_BE, bus.dmaTx2mif_addr); end
    repeat (4) @(posedge core_clk);
    #1;
    if (dn_n != db) begin errors++; $display("FAIL swrst_nodn: got %0d dn pulses want 0", dn_n - db); end
    flush();
    wb = wr_n;
    push(32'hF000_0001); push(32'hF000_0002);
    run_xfer(20'd8, 32'h130, 1, 0, got, dn_at, sbad);
    checks += 2;
    if (!got || wr_n - wb != 2) begin errors++; $display("FAIL swrst_restart: got dn=%0d wr=%0d want 1/2", got, wr_n - wb); end
    if (log_addr[wb] !== 32'h130 || log_data[wb] !== 32'hF000_0001 || log_addr[wb+1] !== 32'h134) begin errors++;
      $display("FAIL swrst_restart_wr: got %h/%h,%h want 130/f0000001,134", log_addr[wb], log_data[wb], log_addr[wb+1]); end
    $display("sw_rst: aborted, restart dn at cycle %0d", dn_at);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 32; i++) fifo_mem[i] = '0;
    bus.sept2dmaTx_sRdAddr = 32'h8000_0000;
    bus.sept2dmaTx_laddrIn = '0;
    bus.sept2dmaTx_dmaStart = 1'b0;
    bus.sept2dmaTx_len = '0;
    bus.sept2dmaTx_epStartAddr = 32'h100;
    bus.sept2dmaTx_epEndAddr = 32'h13C;
    bus.sept2dmaTx_sRdWr = 1'b1;
    bus.ahbm2dmaTx_dn = 1'b0;
    bus.mif2dmaTx_ack = 1'b1;
    test_reset();
    test_len16();
    test_len7();
    test_wrap();
    test_ack_stall();
    test_len0();
    test_sw_rst();
    checks++;
    if (dn_busy != 0) begin errors++; $display("FAIL dn_while_busy: got %0d want 0", dn_busy); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
